sound_scheduler: RTL and testbench

Sequences the audio sample-address counter on behalf of the game FSM, which raises one-cycle play requests. The block latches up to one pending request per sound channel and picks the highest-priority pending channel. It then steps a sample address at the 8 kHz strobe rate until the selected clip ends. It sits between the game controller and the audio BRAM/PWM path, replacing the free-running address counter and the sound_type-based length selection.

---
 rtl/sound_scheduler_pkg.sv | 24 ++
 rtl/sound_scheduler_prio_enc.sv | 27 ++
 rtl/sound_scheduler.sv | 132 +++++++++++++
 tb/tb_sound_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_scheduler_pkg.sv
// Shared audio definitions: sound channels, scheduler states, clip lengths.
// Used by the audio path and by sound_scheduler.
package sound_scheduler_pkg;

    typedef enum logic [1:0] {
        CH_CHOMP = 2'd0,
        CH_WIN   = 2'd1,
        CH_INTRO = 2'd2,
        CH_DEATH = 2'd3
    } snd_chan_t;

    typedef enum logic [1:0] {
        SND_IDLE   = 2'd0,
        SND_PLAY   = 2'd1,
        SND_FINISH = 2'd2
    } snd_state_t;

    localparam int SND_CHAN_N    = 4;
    localparam int SND_CHOMP_LEN = 5735;
    localparam int SND_WIN_LEN   = 4096;
    localparam int SND_INTRO_LEN = 12279;
    localparam int SND_DEATH_LEN = 33735;

endpackage

// File: rtl/sound_scheduler_prio_enc.sv
// Priority encoder over pending sound requests (death highest, chomp lowest).
// Also flags whether the winner outranks the channel currently playing.
module snd_prio_enc
    import sound_scheduler_pkg::*;
(
    input  logic [SND_CHAN_N-1:0] pend_i,
    input  snd_chan_t             cur_i,
    output snd_chan_t             top_o,
    output logic                  any_o,
    output logic                  higher_o
);

    always_comb begin
        top_o = CH_CHOMP;
        if (pend_i[3]) begin
            top_o = CH_DEATH;
        end else if (pend_i[2]) begin
            top_o = CH_INTRO;
        end else if (pend_i[1]) begin
            top_o = CH_WIN;
        end
    end

    assign any_o    = |pend_i;
    assign higher_o = any_o && (top_o > cur_i);

endmodule

// File: rtl/sound_scheduler.sv
// Audio clip scheduler: latches play requests, plays highest priority clip.
// Define SOUND_PREEMPT_EN to let higher-priority requests abort playback.
module sound_scheduler
    import sound_scheduler_pkg::*;
#(
    parameter int CHOMP_LEN = SND_CHOMP_LEN,
    parameter int WIN_LEN   = SND_WIN_LEN,
    parameter int INTRO_LEN = SND_INTRO_LEN,
    parameter int DEATH_LEN = SND_DEATH_LEN,
    parameter int ADDR_W    = 16
) (
    input  logic                  clk_25MHZ,
    input  logic                  rst,
    input  logic                  clk_8KHZ,
    input  logic [SND_CHAN_N-1:0] req,
    input  logic                  stop,
    output logic [ADDR_W-1:0]     play_addr,
    output snd_chan_t             play_chan,
    output logic                  playing,
    output logic                  done,
    output logic [SND_CHAN_N-1:0] pending
);

    localparam logic [ADDR_W-1:0] CHOMP_LAST = ADDR_W'(CHOMP_LEN - 1);
    localparam logic [ADDR_W-1:0] WIN_LAST   = ADDR_W'(WIN_LEN - 1);
    localparam logic [ADDR_W-1:0] INTRO_LAST = ADDR_W'(INTRO_LEN - 1);
    localparam logic [ADDR_W-1:0] DEATH_LAST = ADDR_W'(DEATH_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    snd_state_t            state_q, state_d;
    snd_chan_t             chan_q, chan_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SND_CHAN_N-1:0] pend_q, pend_d;
    logic [SND_CHAN_N-1:0] clr;
    logic [ADDR_W-1:0]     last_addr;
    snd_chan_t             top;
    logic                  any;
    logic                  higher;
    logic                  preempt;

    snd_prio_enc u_prio (
        .pend_i   (pend_q),
        .cur_i    (chan_q),
        .top_o    (top),
        .any_o    (any),
        .higher_o (higher)
    );

`ifdef SOUND_PREEMPT_EN
    assign preempt = higher;
`else
    logic higher_unused;
    assign higher_unused = higher;
    assign preempt       = 1'b0;
`endif

    always_comb begin
        unique case (chan_q)
            CH_CHOMP: last_addr = CHOMP_LAST;
            CH_WIN:   last_addr = WIN_LAST;
            CH_INTRO: last_addr = INTRO_LAST;
            CH_DEATH: last_addr = DEATH_LAST;
        endcase
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        addr_d  = addr_q;
        clr     = '0;
        unique case (state_q)
            SND_IDLE: begin
                if (any) begin
                    state_d    = SND_PLAY;
                    chan_d     = top;
                    addr_d     = '0;
                    clr[top]   = 1'b1;
                end
            end
            SND_PLAY: begin
                if (preempt) begin
                    chan_d   = top;
                    addr_d   = '0;
                    clr[top] = 1'b1;
                end else if (clk_8KHZ) begin
                    if (addr_q == last_addr) begin
                        state_d = SND_FINISH;
                    end else begin
                        addr_d = addr_q + ONE;
                    end
                end
            end
            SND_FINISH: begin
                state_d = SND_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = SND_IDLE;
                addr_d  = '0;
            end
        endcase
        // A new request beats the selection clear in the same cycle
        pend_d = (pend_q & ~clr) | req;
        if (stop) begin
            state_d = SND_IDLE;
            chan_d  = chan_q;
            addr_d  = '0;
            pend_d  = '0;
        end
    end

    always_ff @(posedge clk_25MHZ or posedge rst) begin
        if (rst) begin
            state_q <= SND_IDLE;
            chan_q  <= CH_CHOMP;
            addr_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
        end
    end

    assign play_addr = addr_q;
    assign play_chan = chan_q;
    assign playing   = (state_q == SND_PLAY);
    assign done      = (state_q == SND_FINISH);
    assign pending   = pend_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler with short clip lengths.
// Honours SOUND_PREEMPT_EN to pick the expected preemption behaviour.
module tb_sound_scheduler;
    import sound_scheduler_pkg::*;

    localparam int AW = 16;

    typedef struct packed {
        logic        dn;
        logic [1:0]  ch;
        logic [15:0] ad;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          strb;
    logic          stop;
    logic [3:0]    req;
    logic [AW-1:0] play_addr;
    snd_chan_t     play_chan;
    logic          playing;
    logic          done;
    logic [3:0]    pending;

    ev_t sb[$];
    ev_t mon_e;
    int  n_chk  = 0;
    int  n_fail = 0;
    int  n_done = 0;
    bit  strb_en = 1'b0;

    sound_scheduler #(
        .CHOMP_LEN (4),
        .WIN_LEN   (5),
        .INTRO_LEN (6),
        .DEATH_LEN (7),
        .ADDR_W    (AW)
    ) dut (
        .clk_25MHZ (clk),
        .rst       (rst),
        .clk_8KHZ  (strb),
        .req       (req),
        .stop      (stop),
        .play_addr (play_addr),
        .play_chan (play_chan),
        .playing   (playing),
        .done      (done),
        .pending   (pending)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clip_len(input snd_chan_t c);
        case (c)
            CH_CHOMP: return 4;
            CH_WIN:   return 5;
            CH_INTRO: return 6;
            default:  return 7;
        endcase
    endfunction

    task automatic push_clip(input snd_chan_t c, input int n_smp, input bit with_done);
        for (int a = 0; a < n_smp; a++) begin
            sb.push_back('{dn: 1'b0, ch: c, ad: 16'(a)});
        end
        if (with_done) begin
            sb.push_back('{dn: 1'b1, ch: c, ad: 16'(clip_len(c) - 1)});
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] r);
        req = r;
        cyc();
        req = 4'b0;
    endtask

    task automatic wait_addr(input int a);
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (playing && play_addr == 16'(a)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_addr_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !playing && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        strb = 1'b0;
        forever begin
            repeat (7) @(posedge clk);
            #1 strb = strb_en;
            @(posedge clk);
            #1 strb = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (playing && strb) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_sample", 32'({1'b0, play_chan, play_addr}), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sample", 32'({1'b0, play_chan, play_addr}), 32'(mon_e));
                end
            end
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("sb_extra_done", 32'({1'b1, play_chan, play_addr}), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done", 32'({1'b1, play_chan, play_addr}), 32'(mon_e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst  = 1'b1;
        stop = 1'b0;
        req  = 4'b0;
        cyc(2);
        @(negedge clk);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_addr", 32'(play_addr), 32'd0);
        chk("rst_chan", 32'(play_chan), 32'(CH_CHOMP));
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        cyc();
        rst = 1'b0;
        cyc(3);
        strb_en = 1'b1;

        // single chomp clip
        d0 = n_done;
        push_clip(CH_CHOMP, 4, 1'b1);
        pulse_req(4'b0001);
        @(negedge clk);
        chk("chomp_pend", 32'(pending), 32'h1);
        chk("chomp_idle", 32'(playing), 32'd0);
        cyc();
        @(negedge clk);
        chk("chomp_play", 32'(playing), 32'd1);
        chk("chomp_addr0", 32'(play_addr), 32'd0);
        chk("chomp_pclr", 32'(pending), 32'd0);
        wait_idle();
        chk("chomp_ndone", 32'(n_done - d0), 32'd1);

        // death and chomp together: death first
        d0 = n_done;
        push_clip(CH_DEATH, 7, 1'b1);
        push_clip(CH_CHOMP, 4, 1'b1);
        pulse_req(4'b1001);
        cyc();
        @(negedge clk);
        chk("simul_chan", 32'(play_chan), 32'(CH_DEATH));
        chk("simul_pend", 32'(pending), 32'h1);
        wait_idle();
        chk("simul_ndone", 32'(n_done - d0), 32'd2);

        // death request while intro is at address 3
        d0 = n_done;
`ifdef SOUND_PREEMPT_EN
        push_clip(CH_INTRO, 3, 1'b0);
`else
        push_clip(CH_INTRO, 6, 1'b1);
`endif
        pulse_req(4'b0100);
        wait_addr(3);
        push_clip(CH_DEATH, 7, 1'b1);
        pulse_req(4'b1000);
        @(negedge clk);
        chk("pre_pend", 32'(pending), 32'h8);
        chk("pre_chan_a", 32'(play_chan), 32'(CH_INTRO));
        cyc();
        @(negedge clk);
`ifdef SOUND_PREEMPT_EN
        chk("pre_chan_b", 32'(play_chan), 32'(CH_DEATH));
        chk("pre_addr_b", 32'(play_addr), 32'd0);
        chk("pre_pend_b", 32'(pending), 32'd0);
`else
        chk("pre_chan_b", 32'(play_chan), 32'(CH_INTRO));
        chk("pre_addr_b", 32'(play_addr), 32'd3);
        chk("pre_pend_b", 32'(pending), 32'h8);
`endif
        wait_idle();
`ifdef SOUND_PREEMPT_EN
        chk("pre_ndone", 32'(n_done - d0), 32'd1);
`else
        chk("pre_ndone", 32'(n_done - d0), 32'd2);
`endif

        // replay of the channel that is playing
        d0 = n_done;
        push_clip(CH_CHOMP, 4, 1'b1);
        push_clip(CH_CHOMP, 4, 1'b1);
        pulse_req(4'b0001);
        cyc(3);
        pulse_req(4'b0001);
        @(negedge clk);
        chk("replay_pend", 32'(pending), 32'h1);
        chk("replay_play", 32'(playing), 32'd1);
        wait_idle();
        chk("replay_ndone", 32'(n_done - d0), 32'd2);

        // stop with a simultaneous intro request
        d0 = n_done;
        push_clip(CH_DEATH, 2, 1'b0);
        pulse_req(4'b1000);
        wait_addr(2);
        cyc();
        stop = 1'b1;
        req  = 4'b0100;
        cyc();
        stop = 1'b0;
        req  = 4'b0;
        @(negedge clk);
        chk("stop_playing", 32'(playing), 32'd0);
        chk("stop_addr", 32'(play_addr), 32'd0);
        chk("stop_pend", 32'(pending), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        cyc(20);
        @(negedge clk);
        chk("stop_still_idle", 32'(playing), 32'd0);
        chk("stop_sb", 32'(sb.size()), 32'd0);
        chk("stop_ndone", 32'(n_done - d0), 32'd0);

        // asynchronous reset mid-clip with a queued request
        push_clip(CH_WIN, 2, 1'b0);
        pulse_req(4'b0010);
        wait_addr(2);
        pulse_req(4'b0001);
        @(negedge clk);
        chk("ar_pend_before", 32'(pending), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("ar_playing", 32'(playing), 32'd0);
        chk("ar_addr", 32'(play_addr), 32'd0);
        chk("ar_pend", 32'(pending), 32'd0);
        chk("ar_chan", 32'(play_chan), 32'(CH_CHOMP));
        cyc(2);
        rst = 1'b0;
        cyc(10);
        @(negedge clk);
        chk("ar_idle_after", 32'(playing), 32'd0);
        chk("ar_sb", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
